// File: rtl/sha256_pkg.sv
// -----------------------------------------------------------------------------
// sha256_pkg
// Shared definitions for the SHA-256 message packer: FSM state encoding,
// block-buffer operation codes, block geometry constants, the default
// start delay towards the core and a bit-length helper.
// -----------------------------------------------------------------------------
package sha256_pkg;

    localparam int         SHA256_BLOCK_BYTES = 64;
    localparam int         SHA256_LEN_POS     = 56;
    localparam logic [7:0] SHA256_PAD_BYTE    = 8'h80;
    // Two synchroniser flops in the core plus its IDLE->LOAD transition.
    localparam int         SHA256_START_DELAY = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_PAD  = 3'd2,
        ST_LEN  = 3'd3,
        ST_WAIT = 3'd4,
        ST_SEND = 3'd5
    } mp_state_e;

    typedef enum logic [2:0] {
        BUF_NOP = 3'd0,
        BUF_CLR = 3'd1,
        BUF_WR  = 3'd2,
        BUF_PAD = 3'd3,
        BUF_LEN = 3'd4
    } buf_op_e;

    // Message length in bits from a byte count.
    function automatic logic [63:0] bit_length(input logic [63:0] byte_count);
        return byte_count << 3;
    endfunction

endpackage

// File: rtl/sha256_blk_buf.sv
// -----------------------------------------------------------------------------
// sha256_blk_buf
// 16 x 32-bit block buffer with big-endian byte lanes.
// Byte n lives in word n/4, lane 3-(n%4).
// Ports:
//   clk, rst    clock, synchronous active-high reset (clears the buffer)
//   op_i        operation (sha256_pkg::buf_op_e): NOP, CLR, WR, PAD, LEN
//   pos_i       byte position for WR / PAD
//   byte_i      byte written by WR
//   len_i       64-bit bit length written to words 14/15 by LEN
//   rd_idx_i    word read index
//   rd_word_o   word read data
// PAD writes 0x80 at pos_i and zeroes every byte after it.
// -----------------------------------------------------------------------------
module sha256_blk_buf
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  op_i,
    input  logic [5:0]  pos_i,
    input  logic [7:0]  byte_i,
    input  logic [63:0] len_i,
    input  logic [3:0]  rd_idx_i,
    output logic [31:0] rd_word_o
);

    logic [31:0] mem_q [16];
    buf_op_e     op_s;

    assign op_s      = buf_op_e'(op_i);
    assign rd_word_o = mem_q[rd_idx_i];

    // Buffer storage: reset/clear, byte-lane writes, padding and length words.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < 16; w++) begin
                mem_q[w] <= 32'h0000_0000;
            end
        end else begin
            case (op_s)
                BUF_CLR: begin
                    for (int w = 0; w < 16; w++) begin
                        mem_q[w] <= 32'h0000_0000;
                    end
                end
                BUF_WR: begin
                    mem_q[pos_i[5:2]][{~pos_i[1:0], 3'b000} +: 8] <= byte_i;
                end
                BUF_PAD: begin
                    for (int w = 0; w < 16; w++) begin
                        for (int l = 0; l < 4; l++) begin
                            if (6'(w * 4 + l) == pos_i) begin
                                mem_q[w][8 * (3 - l) +: 8] <= SHA256_PAD_BYTE;
                            end else if (6'(w * 4 + l) > pos_i) begin
                                mem_q[w][8 * (3 - l) +: 8] <= 8'h00;
                            end
                        end
                    end
                end
                BUF_LEN: begin
                    mem_q[14] <= len_i[63:32];
                    mem_q[15] <= len_i[31:0];
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/sha256_msg_packer.sv
// -----------------------------------------------------------------------------
// sha256_msg_packer
// Collects message bytes from the UART receiver into 64-byte blocks, applies
// SHA-256 padding (0x80, zero fill, 64-bit big-endian bit length; may spill
// into an extra block) and streams each block to the SHA-256 core as a
// one-cycle MP_dv_out pulse followed, START_DELAY cycles later, by 16
// big-endian words on message_out.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rx_byte_in      message byte; transfers when rx_dv_in && rx_ready_out
//   rx_dv_in        byte valid
//   rx_last_in      transferring byte is the final message byte
//   rx_empty_in     one-cycle pulse: zero-length message (IDLE only)
//   rx_ready_out    packer can accept a byte (IDLE or FILL)
//   core_idle_in    core can take a new block
//   MP_dv_out       block-start pulse
//   message_out     block word, valid START_DELAY..START_DELAY+15 after pulse
//   block_last_out  final block of a message, pulse through word 15
//   busy_out        FSM not in IDLE
//   err_out         (SHA256_MP_ERR_EN only) sticky protocol error
// Optional feature macro: SHA256_MP_ERR_EN.
// -----------------------------------------------------------------------------
module sha256_msg_packer
    import sha256_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int START_DELAY = SHA256_START_DELAY,
    parameter int LEN_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_byte_in,
    input  logic                  rx_dv_in,
    input  logic                  rx_last_in,
    input  logic                  rx_empty_in,
    output logic                  rx_ready_out,
    input  logic                  core_idle_in,
    output logic                  MP_dv_out,
    output logic [DATA_WIDTH-1:0] message_out,
    output logic                  block_last_out,
    output logic                  busy_out
`ifdef SHA256_MP_ERR_EN
    ,
    output logic                  err_out
`endif
);

    localparam int SEND_LAST = START_DELAY + 15;
    localparam int CNT_W     = $clog2(SEND_LAST + 2);

    mp_state_e             state_q;
    logic [5:0]            byte_cnt_q;
    logic [LEN_WIDTH-1:0]  total_q;
    logic                  full_q;     // block filled by exactly 64 bytes: 0x80 goes to next block
    logic                  pend_q;     // a length-only block still has to follow
    logic                  final_q;    // buffered block is the last of the message
    logic [CNT_W-1:0]      send_cnt_q;
    logic                  mp_dv_q;
    logic                  blk_last_q;
    logic [DATA_WIDTH-1:0] msg_q;

    logic                  xfer_s;
    logic                  send_end_s;
    logic [CNT_W-1:0]      send_nxt_s;
    logic                  in_window_s;
    logic [3:0]            rd_idx_s;
    logic [31:0]           rd_word_s;
    logic [63:0]           len_bits_s;
    buf_op_e               buf_op_s;
    logic [5:0]            buf_pos_s;

    assign rx_ready_out   = (state_q == ST_IDLE) || (state_q == ST_FILL);
    assign busy_out       = (state_q != ST_IDLE);
    assign MP_dv_out      = mp_dv_q;
    assign message_out    = msg_q;
    assign block_last_out = blk_last_q;

    assign xfer_s      = rx_dv_in && rx_ready_out;
    assign send_end_s  = (send_cnt_q == CNT_W'(SEND_LAST));
    assign send_nxt_s  = send_cnt_q + CNT_W'(1);
    // Outputs are registered, so the word for cycle c+1 is fetched in cycle c.
    assign in_window_s = (send_nxt_s >= CNT_W'(START_DELAY)) && (send_nxt_s <= CNT_W'(SEND_LAST));
    assign rd_idx_s    = 4'(send_nxt_s - CNT_W'(START_DELAY));
    assign len_bits_s  = bit_length(64'(total_q));

    // Buffer operation selected by the current state and the byte handshake.
    always_comb begin
        buf_op_s  = BUF_NOP;
        buf_pos_s = byte_cnt_q;
        case (state_q)
            ST_IDLE: begin
                buf_pos_s = 6'd0;
                if (xfer_s) begin
                    buf_op_s = BUF_WR;
                end else begin
                    buf_op_s = BUF_NOP;
                end
            end
            ST_FILL: begin
                if (xfer_s) begin
                    buf_op_s = BUF_WR;
                end else begin
                    buf_op_s = BUF_NOP;
                end
            end
            ST_PAD: begin
                if (full_q) begin
                    buf_op_s = BUF_NOP;
                end else begin
                    buf_op_s = BUF_PAD;
                end
            end
            ST_LEN: begin
                buf_op_s = BUF_LEN;
            end
            ST_SEND: begin
                if (!send_end_s) begin
                    buf_op_s = BUF_NOP;
                end else if (pend_q && full_q) begin
                    // Padding block of a 64-byte-aligned message: 0x80 at byte 0, rest zero.
                    buf_op_s  = BUF_PAD;
                    buf_pos_s = 6'd0;
                end else begin
                    buf_op_s = BUF_CLR;
                end
            end
            default: begin
                buf_op_s = BUF_NOP;
            end
        endcase
    end

    sha256_blk_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .op_i      (buf_op_s),
        .pos_i     (buf_pos_s),
        .byte_i    (rx_byte_in),
        .len_i     (len_bits_s),
        .rd_idx_i  (rd_idx_s),
        .rd_word_o (rd_word_s)
    );

    // Packer FSM with its counters, flags and registered core-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= 6'd0;
            total_q    <= '0;
            full_q     <= 1'b0;
            pend_q     <= 1'b0;
            final_q    <= 1'b0;
            send_cnt_q <= '0;
            mp_dv_q    <= 1'b0;
            blk_last_q <= 1'b0;
            msg_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (xfer_s) begin
                        byte_cnt_q <= 6'd1;
                        total_q    <= LEN_WIDTH'(1);
                        full_q     <= 1'b0;
                        state_q    <= rx_last_in ? ST_PAD : ST_FILL;
                    end else if (rx_empty_in) begin
                        byte_cnt_q <= 6'd0;
                        total_q    <= '0;
                        full_q     <= 1'b0;
                        state_q    <= ST_PAD;
                    end
                end
                ST_FILL: begin
                    if (xfer_s) begin
                        byte_cnt_q <= byte_cnt_q + 6'd1;
                        total_q    <= total_q + LEN_WIDTH'(1);
                        if (byte_cnt_q == 6'(SHA256_BLOCK_BYTES - 1)) begin
                            full_q <= 1'b1;
                            if (rx_last_in) begin
                                state_q <= ST_PAD;
                            end else begin
                                pend_q  <= 1'b0;
                                final_q <= 1'b0;
                                state_q <= ST_WAIT;
                            end
                        end else if (rx_last_in) begin
                            state_q <= ST_PAD;
                        end
                    end
                end
                ST_PAD: begin
                    // Length fits when the byte after 0x80 is at or before SHA256_LEN_POS.
                    if (!full_q && (byte_cnt_q <= 6'(SHA256_LEN_POS - 1))) begin
                        state_q <= ST_LEN;
                    end else begin
                        pend_q  <= 1'b1;
                        final_q <= 1'b0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_LEN: begin
                    pend_q  <= 1'b0;
                    final_q <= 1'b1;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (core_idle_in) begin
                        send_cnt_q <= '0;
                        mp_dv_q    <= 1'b1;
                        blk_last_q <= final_q;
                        state_q    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    mp_dv_q <= 1'b0;
                    if (send_end_s) begin
                        msg_q      <= '0;
                        blk_last_q <= 1'b0;
                        if (pend_q) begin
                            state_q <= ST_LEN;
                        end else if (final_q) begin
                            state_q <= ST_IDLE;
                        end else begin
                            full_q     <= 1'b0;
                            byte_cnt_q <= 6'd0;
                            state_q    <= ST_FILL;
                        end
                    end else begin
                        send_cnt_q <= send_nxt_s;
                        msg_q      <= in_window_s ? DATA_WIDTH'(rd_word_s) : '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SHA256_MP_ERR_EN
    logic [6:0] stall_cnt_q;
    logic       err_q;

    assign err_out = err_q;

    // Sticky error: valid stalled for more than 64 cycles, or empty pulse outside IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 7'd0;
            err_q       <= 1'b0;
        end else begin
            if (rx_dv_in && !rx_ready_out) begin
                if (stall_cnt_q != 7'd64) begin
                    stall_cnt_q <= stall_cnt_q + 7'd1;
                end else begin
                    err_q <= 1'b1;
                end
            end else begin
                stall_cnt_q <= 7'd0;
            end
            if (rx_empty_in && (state_q != ST_IDLE)) begin
                err_q <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sha256_msg_packer.sv
// -----------------------------------------------------------------------------
// tb_sha256_msg_packer
// Self-checking bench: a byte-level SHA-256 padding model pushes expected
// blocks to a scoreboard queue; a monitor pops and compares whole blocks
// when MP_dv_out fires. A vector table adds hand-computed spot values.
// -----------------------------------------------------------------------------
module tb_sha256_msg_packer;

    localparam int SD = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_byte_in;
    logic        rx_dv_in;
    logic        rx_last_in;
    logic        rx_empty_in;
    logic        rx_ready_out;
    logic        core_idle_in;
    logic        MP_dv_out;
    logic [31:0] message_out;
    logic        block_last_out;
    logic        busy_out;
`ifdef SHA256_MP_ERR_EN
    logic        err_out;
`endif

    sha256_msg_packer #(.DATA_WIDTH(32), .START_DELAY(SD), .LEN_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_byte_in     (rx_byte_in),
        .rx_dv_in       (rx_dv_in),
        .rx_last_in     (rx_last_in),
        .rx_empty_in    (rx_empty_in),
        .rx_ready_out   (rx_ready_out),
        .core_idle_in   (core_idle_in),
        .MP_dv_out      (MP_dv_out),
        .message_out    (message_out),
        .block_last_out (block_last_out),
        .busy_out       (busy_out)
`ifdef SHA256_MP_ERR_EN
        ,
        .err_out        (err_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              last;
        logic [15:0][31:0] w;
    } blk_t;

    typedef struct {
        int          len;
        logic [7:0]  base;
        bit          gap;
        int          nblk;
        logic [31:0] w0;
        logic [31:0] w15;
    } vec_t;

    blk_t exp_q[$];
    blk_t last_blk;
    int   blk_cnt   = 0;
    int   errors    = 0;
    int   checks    = 0;
    bit   abort_req = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference padding: bytes, 0x80, zeros to 56 mod 64, big-endian bit length.
    task automatic push_expected(input int len, input logic [7:0] base);
        logic [7:0]  m[$];
        logic [63:0] bits;
        blk_t        b;
        int          nblk;
        for (int i = 0; i < len; i++) m.push_back(8'(base + i));
        m.push_back(8'h80);
        while ((m.size() % 64) != 56) m.push_back(8'h00);
        bits = 64'(len) << 3;
        for (int k = 7; k >= 0; k--) m.push_back(bits[8*k +: 8]);
        nblk = m.size() / 64;
        for (int bi = 0; bi < nblk; bi++) begin
            for (int k = 0; k < 16; k++) begin
                b.w[k] = {m[bi*64 + 4*k], m[bi*64 + 4*k + 1], m[bi*64 + 4*k + 2], m[bi*64 + 4*k + 3]};
            end
            b.last = (bi == nblk - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic send_msg(input int len, input logic [7:0] base, output int stalls);
        int t;
        stalls = 0;
        if (len == 0) begin
            rx_empty_in = 1'b1;
            @(negedge clk);
            rx_empty_in = 1'b0;
        end else begin
            for (int i = 0; i < len; i++) begin
                rx_byte_in = 8'(base + i);
                rx_last_in = (i == len - 1);
                rx_dv_in   = 1'b1;
                t = 0;
                while (!rx_ready_out && t < 500) begin
                    @(negedge clk);
                    stalls++;
                    t++;
                end
                if (t >= 500) check("ready_timeout", 64'd0, 64'd1);
                @(negedge clk);
            end
            rx_dv_in   = 1'b0;
            rx_last_in = 1'b0;
        end
    endtask

    task automatic wait_pulse();
        int t = 0;
        while (MP_dv_out !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) check("pulse_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy_out !== 1'b0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) check("idle_timeout", 64'd0, 64'd1);
        repeat (2) @(negedge clk);
    endtask

    // Block monitor: pops the expected block on each pulse and checks timing and words.
    always begin
        blk_t e;
        blk_t got;
        bit   ab;
        @(negedge clk);
        if (MP_dv_out === 1'b1) begin
            ab  = 1'b0;
            got = '0;
            if (exp_q.size() == 0) begin
                check("unexpected_block", 64'd1, 64'd0);
                e = '0;
            end else begin
                e = exp_q.pop_front();
            end
            check("last_at_pulse", 64'(block_last_out), 64'(e.last));
            for (int c = 1; c <= SD + 15; c++) begin
                @(negedge clk);
                if (abort_req) begin
                    ab        = 1'b1;
                    abort_req = 1'b0;
                    break;
                end
                if (c == 1) check("pulse_one_cycle", 64'(MP_dv_out), 64'd0);
                if (c < SD) check("pre_window_zero", 64'(message_out), 64'd0);
                else        got.w[c - SD] = message_out;
                if (c == SD + 15) got.last = block_last_out;
            end
            if (!ab) begin
                for (int k = 0; k < 16; k++) begin
                    check($sformatf("blk%0d_word%0d", blk_cnt, k), 64'(got.w[k]), 64'(e.w[k]));
                end
                check("last_at_word15", 64'(got.last), 64'(e.last));
                last_blk = got;
                blk_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        int   c0;
        int   st;
        int   bad;

        vecs[0] = '{len: 3,   base: 8'h61, gap: 1'b0, nblk: 1, w0: 32'h6162_6380, w15: 32'h0000_0018};
        vecs[1] = '{len: 0,   base: 8'h00, gap: 1'b0, nblk: 1, w0: 32'h8000_0000, w15: 32'h0000_0000};
        vecs[2] = '{len: 56,  base: 8'h00, gap: 1'b0, nblk: 2, w0: 32'h0000_0000, w15: 32'h0000_01C0};
        vecs[3] = '{len: 64,  base: 8'h00, gap: 1'b1, nblk: 2, w0: 32'h8000_0000, w15: 32'h0000_0200};
        vecs[4] = '{len: 55,  base: 8'h10, gap: 1'b0, nblk: 1, w0: 32'h1011_1213, w15: 32'h0000_01B8};
        vecs[5] = '{len: 1,   base: 8'hA5, gap: 1'b0, nblk: 1, w0: 32'hA580_0000, w15: 32'h0000_0008};
        vecs[6] = '{len: 65,  base: 8'h00, gap: 1'b0, nblk: 2, w0: 32'h4080_0000, w15: 32'h0000_0208};
        vecs[7] = '{len: 120, base: 8'h00, gap: 1'b0, nblk: 3, w0: 32'h0000_0000, w15: 32'h0000_03C0};

        rst          = 1'b1;
        rx_byte_in   = 8'h00;
        rx_dv_in     = 1'b0;
        rx_last_in   = 1'b0;
        rx_empty_in  = 1'b0;
        core_idle_in = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mp_dv",    64'(MP_dv_out),      64'd0);
        check("rst_message",  64'(message_out),    64'd0);
        check("rst_blk_last", 64'(block_last_out), 64'd0);
        check("rst_busy",     64'(busy_out),       64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 64'(rx_ready_out), 64'd1);

        for (int i = 0; i < 8; i++) begin
            c0 = blk_cnt;
            push_expected(vecs[i].len, vecs[i].base);
            send_msg(vecs[i].len, vecs[i].base, st);
            if (vecs[i].gap) begin
                // Stall the core between the two blocks of this message.
                wait_pulse();
                core_idle_in = 1'b0;
                bad = 0;
                repeat (40) begin
                    @(negedge clk);
                    if (MP_dv_out !== 1'b0 || rx_ready_out !== 1'b0) bad++;
                end
                check("gap_no_pulse_no_ready", 64'(bad), 64'd0);
                core_idle_in = 1'b1;
            end
            wait_idle();
            check($sformatf("v%0d_blocks", i), 64'(blk_cnt - c0), 64'(vecs[i].nblk));
            check($sformatf("v%0d_w0", i),     64'(last_blk.w[0]),  64'(vecs[i].w0));
            check($sformatf("v%0d_w15", i),    64'(last_blk.w[15]), 64'(vecs[i].w15));
            check($sformatf("v%0d_last", i),   64'(last_blk.last),  64'd1);
        end

        // Byte held valid during SEND is only accepted once the block is out.
        c0 = blk_cnt;
        push_expected(2, 8'h30);
        push_expected(1, 8'h5A);
        send_msg(2, 8'h30, st);
        wait_pulse();
        send_msg(1, 8'h5A, st);
        check("held_stall_cycles", 64'(st), 64'(SD + 16));
        wait_idle();
        check("held_blocks", 64'(blk_cnt - c0), 64'd2);
        check("held_w0",     64'(last_blk.w[0]),  64'h5A80_0000);
        check("held_w15",    64'(last_blk.w[15]), 64'h0000_0008);

        // Reset in the middle of SEND aborts the block.
        c0 = blk_cnt;
        push_expected(3, 8'h61);
        send_msg(3, 8'h61, st);
        wait_pulse();
        repeat (SD + 5) @(negedge clk);
        abort_req = 1'b1;
        rst       = 1'b1;
        @(negedge clk);
        check("abort_message", 64'(message_out), 64'd0);
        check("abort_mp_dv",   64'(MP_dv_out),   64'd0);
        check("abort_busy",    64'(busy_out),    64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_no_block", 64'(blk_cnt - c0), 64'd0);
        c0 = blk_cnt;
        push_expected(3, 8'h61);
        send_msg(3, 8'h61, st);
        wait_idle();
        check("post_rst_blocks", 64'(blk_cnt - c0),    64'd1);
        check("post_rst_w0",     64'(last_blk.w[0]),  64'h6162_6380);
        check("post_rst_w15",    64'(last_blk.w[15]), 64'h0000_0018);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha256_msg_packer.md
Name: sha256_msg_packer

Overview:
- Upstream neighbour of the SHA-256 core; sits between the UART receiver and the core.
- Collects message bytes into a 64-byte block buffer and applies SHA-256 padding (0x80, zero fill, 64-bit big-endian bit length). Padding may spill into an extra block.
- Hands each 512-bit block to the core as a one-cycle data-valid pulse followed by 16 big-endian 32-bit words, one per cycle, timed to the core's 2-flop input synchroniser and LOAD state.

Parameters:
- DATA_WIDTH, 32, word width on message_out; only 32 is supported.
- START_DELAY, 3, cycles from the MP_dv_out pulse to the first word on message_out. Matches the core: 2 sync flops plus the IDLE->LOAD transition.
- LEN_WIDTH, 32, width of the internal byte counter (bit length = count*8, zero-extended to 64 bits).

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- rx_byte_in  in  8  message byte from the UART receiver.
- rx_dv_in  in  1  rx_byte_in valid; a byte transfers when rx_dv_in && rx_ready_out.
- rx_last_in  in  1  qualifies the transferring byte as the final message byte.
- rx_empty_in  in  1  one-cycle pulse: zero-length message (end of message with no data).
- rx_ready_out  out  1  packer can accept a byte this cycle.
- core_idle_in  in  1  core is in IDLE and may take a new block.
- MP_dv_out  out  1  one-cycle block-start pulse to the core.
- message_out  out  DATA_WIDTH  block word; valid in cycles START_DELAY..START_DELAY+15 after the pulse.
- block_last_out  out  1  high from the pulse through word 15 of the final block of a message.
- busy_out  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, byte/word counters 0, buffer cleared.
- Buffer: 16 x 32-bit words. Byte n of a block goes to word n/4, lane 3-(n%4) (big-endian). Byte counter is mod 64 within a block; the total byte count is LEN_WIDTH bits and wraps silently.
- States:
  - IDLE: rx_ready_out=1.
    - First transfer -> FILL (byte stored).
    - rx_empty_in -> PAD.
  - FILL: rx_ready_out=1 while the block has fewer than 64 bytes.
    - Byte with rx_last_in -> PAD.
    - 64th byte without last -> WAIT (block not final).
  - PAD: one cycle. Writes 0x80 at the next byte position and zeroes the rest of the block.
    - If position after 0x80 <= 56 -> LEN.
    - Else -> WAIT with a pending-length flag set.
  - LEN: writes the 64-bit bit length into words 14-15 -> WAIT (final).
  - WAIT: waits for core_idle_in=1, then -> SEND.
  - SEND: counter 0..START_DELAY+15.
    - Cycle 0: MP_dv_out=1.
    - Cycle START_DELAY+k: message_out = word k. message_out is 0 outside this window.
    - At end of SEND:
      - Pending-length block -> clear buffer, LEN.
      - Non-final full block -> FILL with new block.
      - Final block -> IDLE.
- rx_ready_out=0 in PAD, LEN, WAIT and SEND. Upstream must hold the byte (valid/ready hold).
- A 64-byte block ending with rx_last_in goes PAD -> WAIT; the padding block is emitted next.
- rx_dv_in and rx_empty_in together: rx_dv_in wins; rx_empty_in is ignored outside IDLE.
- Reset mid-operation: abort immediately. MP_dv_out and message_out go to 0 the next cycle; no partial block is emitted.

Optional Feature:
- Macro: SHA256_MP_ERR_EN.
- Defined:
  - Adds output err_out (1 bit, sticky, cleared by rst).
  - Sets on rx_dv_in=1 while rx_ready_out=0 for more than 64 consecutive cycles (stall overflow).
  - Sets on rx_empty_in outside IDLE.
- Not defined: no err_out port and no error logic; behaviour is otherwise identical.

Decomposition:
- Shared package sha256_pkg:
  - state encoding.
  - SHA256_BLOCK_BYTES=64, SHA256_LEN_POS=56, SHA256_PAD_BYTE=8'h80.
  - START_DELAY default.
- Sub-module sha256_blk_buf: 16x32 byte-lane-writable buffer with clear, byte write, word-14/15 length write and word read.

Test Plan:
- "abc" (0x61,0x62,0x63, last on 0x63), core_idle_in=1 -> one block; word0=0x61626380, words1-14=0, word15=0x00000018; block_last_out=1; word0 appears 3 cycles after MP_dv_out.
- rx_empty_in pulse -> one block; word0=0x80000000, words1-15=0.
- 56 bytes 0x00..0x37 -> two blocks.
  - Block1: words 0-13 data (word0=0x00010203), word14=0x80000000, word15=0, block_last_out=0.
  - Block2: words 0-14=0, word15=0x000001C0, block_last_out=1.
- 64 bytes -> block1 all data; block2 word0=0x80000000, word15=0x00000200. Hold core_idle_in=0 for 20 cycles between blocks -> no MP_dv_out and rx_ready_out=0 until idle.
- rx_dv_in held during SEND -> byte not consumed (rx_ready_out=0); accepted after SEND completes.
- rst asserted at SEND word 5 -> message_out=0, MP_dv_out=0, busy_out=0 next cycle; a following "abc" produces the correct block.
